// File: rtl/multicycle_cpu.sv
// ----------------------------------------------------------------------------
// multicycle_cpu
//   Multi-cycle MIPS-style core. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Instruction and data memories
//   are external and use req/ready handshakes.
//   Supported ISA: R-type add/sub/and/or/slt, addi, lw, sw, beq and halt.
//   Any other opcode or funct stops the core with the illegal flag set.
//
// Parameters
//   DATA_W  datapath and register width (>= 16)
//   PC_W    word-address width of both memories; the pc wraps mod 2^PC_W
//   NREGS   number of implemented registers (8, 16 or 32); r0 reads as 0
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   imem_req/imem_addr              fetch request and word address (= pc)
//   imem_ready/imem_rdata           fetch completion and instruction word
//   dmem_req/dmem_we/dmem_addr      data access request, 1 = store
//   dmem_wdata                      store data (rt value)
//   dmem_ready/dmem_rdata           access completion and load data
//   pc                              current program counter
//   halted                          core stopped (halt or illegal instruction)
//   illegal                         sticky, the stop came from an illegal op
//
// Configuration
//   MULTICYCLE_CPU_BNE_EN  when defined, opcode 0x05 is bne (branch if
//                          rs != rt, same timing as beq); otherwise 0x05 is
//                          treated as illegal.
// ----------------------------------------------------------------------------
module multicycle_cpu #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;
`ifdef MULTICYCLE_CPU_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        dest;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] alu_result;
  logic              op_legal;
  logic              is_mem;
  logic              branch_op;
  logic              branch_taken;
  logic [PC_W-1:0]   pc_seq;
  logic [PC_W-1:0]   pc_branch;

  // Register indices that are r0 or beyond the implemented file are
  // treated as a hard-wired zero: reads return 0 and writes vanish.
  function automatic logic reg_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (int'(idx) < NREGS);
  endfunction

  assign op        = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm_sext  = DATA_W'($signed(ir[15:0]));
  assign dest      = (op == OP_RTYPE) ? rd : rt;
  assign rs_val    = reg_ok(rs) ? regs[rs[RIDX_W-1:0]] : '0;
  assign rt_val    = reg_ok(rt) ? regs[rt[RIDX_W-1:0]] : '0;
  assign is_mem    = (op == OP_LW) || (op == OP_SW);
  assign imem_addr = pc;
  assign pc_seq    = pc + PC_W'(1);
  assign pc_branch = pc_seq + imm_sext[PC_W-1:0];

  // The optional bne shares the beq datapath and only flips the compare.
`ifdef MULTICYCLE_CPU_BNE_EN
  assign branch_op    = (op == OP_BEQ) || (op == OP_BNE);
  assign branch_taken = (op == OP_BEQ) ? (reg_a == reg_b) : (reg_a != reg_b);
`else
  assign branch_op    = (op == OP_BEQ);
  assign branch_taken = (reg_a == reg_b);
`endif

  // Opcode/funct legality check used in DECODE. Halt is handled separately
  // there so it does not count as legal here.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE: op_legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                           (funct == FN_AND) || (funct == FN_OR)  ||
                           (funct == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
`ifdef MULTICYCLE_CPU_BNE_EN
      OP_BNE:   op_legal = 1'b1;
`endif
      default:  op_legal = 1'b0;
    endcase
  end

  // ALU: R-type picks the function by funct; addi/lw/sw all need rs + imm,
  // which doubles as the data memory address for loads and stores.
  always_comb begin
    alu_result = '0;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_result = reg_a + reg_b;
        FN_SUB:  alu_result = reg_a - reg_b;
        FN_AND:  alu_result = reg_a & reg_b;
        FN_OR:   alu_result = reg_a | reg_b;
        FN_SLT:  alu_result = ($signed(reg_a) < $signed(reg_b)) ? DATA_W'(1) : '0;
        default: alu_result = '0;
      endcase
    end else begin
      alu_result = reg_a + imm_sext;
    end
  end

  // Main sequencer. All memory-facing outputs are registered and set on the
  // transition into the state that owns them, so req/addr/we/wdata stay
  // stable for as long as the memory holds ready low. The first FETCH after
  // reset spends one cycle raising imem_req, since reset must leave it low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      result     <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          reg_a <= rs_val;
          reg_b <= rt_val;
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (!op_legal) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (branch_op) begin
            pc       <= branch_taken ? pc_branch : pc_seq;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else if (is_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= (op == OP_SW);
            dmem_addr  <= alu_result[PC_W-1:0];
            dmem_wdata <= reg_b;
            state      <= S_MEM;
          end else begin
            result <= alu_result;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              pc       <= pc_seq;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              result <= dmem_rdata;
              state  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (reg_ok(dest)) begin
            regs[dest[RIDX_W-1:0]] <= result;
          end
          pc       <= pc_seq;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// ----------------------------------------------------------------------------
// tb_multicycle_cpu
//   Directed programs for multicycle_cpu (DATA_W=32, PC_W=8, NREGS=8).
//   An instruction-level model of the ISA steps once per accepted fetch and
//   predicts the next fetch address and any data access; the memory process
//   compares the DUT's requests against it every cycle a request is up.
//   Hand-computed literals pin the store data, addresses, latencies and stop
//   conditions of each program.
// ----------------------------------------------------------------------------
module tb_multicycle_cpu;

  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int NREGS  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ready = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              dmem_req;
  logic              dmem_we;
  logic [PC_W-1:0]   dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready = 1'b0;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic [PC_W-1:0]   pc;
  logic              halted;
  logic              illegal;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  logic [31:0] imem  [0:255];
  logic [31:0] dmem  [0:255];
  logic [31:0] mdmem [0:255];
  logic [31:0] m_regs [0:31];
  logic [7:0]  m_pc;
  logic        m_halted;
  logic        m_illegal;
  exp_t        exp_q [$];

  int total_count = 0;
  int bad_count   = 0;
  int cyc         = 0;
  int imem_wait   = 0;
  int dmem_wait   = 0;
  int spurious    = 0;
  int i_cnt       = 0;
  int d_cnt       = 0;
  int f_n         = 0;
  int d_n         = 0;
  logic [7:0]  f_addr  [0:63];
  int          f_cyc   [0:63];
  logic        d_we    [0:63];
  logic [7:0]  d_addr  [0:63];
  logic [31:0] d_wdata [0:63];

  multicycle_cpu #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .halted(halted), .illegal(illegal)
  );

  // Free-running 100 MHz-style clock and a cycle counter for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: count it, and report a failure with actual and expected.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_count++;
    if (actual !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    return (idx == 5'd0 || int'(idx) >= NREGS) ? 32'd0 : m_regs[idx];
  endfunction

  task automatic mwrite(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0 && int'(idx) < NREGS) m_regs[idx] = val;
  endtask

  // Architectural model: execute one whole instruction, predict the next
  // fetch address and queue the data access it must perform.
  task automatic modelStep(input logic [31:0] instr);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sext;
    logic [31:0] sum;
    logic [7:0]  next_pc;
    logic        stop;
    exp_t        e;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
    rd = instr[15:11]; fn = instr[5:0];
    a = mread(rs); b = mread(rt);
    sext = {{16{instr[15]}}, instr[15:0]};
    sum = a + sext;
    next_pc = m_pc + 8'd1;
    stop = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: mwrite(rd, a + b);
          6'h22: mwrite(rd, a - b);
          6'h24: mwrite(rd, a & b);
          6'h25: mwrite(rd, a | b);
          6'h2A: mwrite(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: begin stop = 1'b1; m_illegal = 1'b1; end
        endcase
      end
      6'h08: mwrite(rt, sum);
      6'h23: begin
        e.we = 1'b0; e.addr = sum[7:0]; e.wdata = b;
        exp_q.push_back(e);
        mwrite(rt, mdmem[sum[7:0]]);
      end
      6'h2B: begin
        e.we = 1'b1; e.addr = sum[7:0]; e.wdata = b;
        exp_q.push_back(e);
        mdmem[sum[7:0]] = b;
      end
      6'h04: if (a == b) next_pc = m_pc + 8'd1 + sext[7:0];
`ifdef MULTICYCLE_CPU_BNE_EN
      6'h05: if (a != b) next_pc = m_pc + 8'd1 + sext[7:0];
`endif
      6'h3F: stop = 1'b1;
      default: begin stop = 1'b1; m_illegal = 1'b1; end
    endcase
    if (stop) m_halted = 1'b1;
    else m_pc = next_pc;
  endtask

  // Memory models plus the per-cycle compare against the ISA model. Runs on
  // the falling edge: checks the DUT's registered requests, then decides
  // whether to answer ready for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_pc = 8'd0; m_halted = 1'b0; m_illegal = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      exp_q.delete();
      i_cnt = 0; d_cnt = 0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
    end else begin
      if (m_halted) checkOutput("no_fetch_after_halt", imem_req, 0);
      if (imem_req) begin
        checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("not_halted_while_fetching", halted, 0);
        if (i_cnt >= imem_wait) begin
          imem_ready = 1'b1;
          imem_rdata = imem[imem_addr];
          if (f_n < 64) begin f_addr[f_n] = imem_addr; f_cyc[f_n] = cyc; end
          f_n++;
          i_cnt = 0;
          if (!m_halted) modelStep(imem[m_pc]);
        end else begin
          imem_ready = 1'b0;
          i_cnt++;
        end
      end else begin
        imem_ready = (spurious != 0) && ($urandom_range(0, 1) == 1);
        imem_rdata = $urandom;
        i_cnt = 0;
      end
      if (dmem_req) begin
        if (exp_q.size() == 0) begin
          checkOutput("dmem_req_unexpected", dmem_req, 0);
        end else begin
          checkOutput("dmem_we", dmem_we, exp_q[0].we);
          checkOutput("dmem_addr", dmem_addr, exp_q[0].addr);
          if (exp_q[0].we) checkOutput("dmem_wdata", dmem_wdata, exp_q[0].wdata);
        end
        if (d_cnt >= dmem_wait) begin
          dmem_ready = 1'b1;
          if (dmem_we) dmem[dmem_addr] = dmem_wdata;
          else dmem_rdata = dmem[dmem_addr];
          if (d_n < 64) begin
            d_we[d_n] = dmem_we; d_addr[d_n] = dmem_addr; d_wdata[d_n] = dmem_wdata;
          end
          d_n++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          d_cnt = 0;
        end else begin
          dmem_ready = 1'b0;
          d_cnt++;
        end
      end else begin
        dmem_ready = (spurious != 0) && ($urandom_range(0, 1) == 1);
        dmem_rdata = $urandom;
        d_cnt = 0;
      end
    end
  end

  // Put the core in reset and wipe both memories: imem fills with halt.
  task automatic holdReset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'hFC00_0000; dmem[i] = 32'd0; mdmem[i] = 32'd0;
    end
  endtask

  // Select memory timing and release reset away from any clock edge.
  task automatic applyStimulus(input int iw, input int dw, input int sp);
    imem_wait = iw; dmem_wait = dw; spurious = sp;
    f_n = 0; d_n = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic runUntilHalt(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    checkOutput("halt_reached", halted, 1);
  endtask

  task automatic waitFetches(input int n, input int budget);
    for (int i = 0; i < budget && f_n < n; i++) @(negedge clk);
    checkOutput("fetch_count_reached", (f_n >= n), 1);
  endtask

  // Watchdog so the run always ends, even if the core wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed programs, one per scenario.
  initial begin
    int req_cycles;

    holdReset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    imem[2] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
    applyStimulus(2, 0, 0);
    for (int i = 0; i < 100 && !(pc == 8'd2 && imem_req); i++) @(negedge clk);
    checkOutput("pc_before_reset", pc, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_imem_req", imem_req, 0);
    checkOutput("reset_pc", pc, 0);
    checkOutput("reset_dmem_req", dmem_req, 0);
    checkOutput("reset_dmem_we", dmem_we, 0);
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_illegal", illegal, 0);
    applyStimulus(2, 0, 0);
    for (int i = 0; i < 5 && !imem_req; i++) @(negedge clk);
    checkOutput("fetch_req_after_reset", imem_req, 1);
    checkOutput("fetch_addr_after_reset", imem_addr, 0);
    runUntilHalt(500);
    checkOutput("t1_pc_halt", pc, 3);

    holdReset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    imem[4] = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);
    imem[5] = enc_i(6'h23, 5'd0, 5'd5, 16'd4);
    imem[6] = enc_i(6'h2B, 5'd0, 5'd5, 16'd8);
    imem[7] = enc_i(6'h2B, 5'd0, 5'd4, 16'd12);
    applyStimulus(0, 2, 0);
    runUntilHalt(500);
    checkOutput("alu_seq_cycles", f_cyc[3] - f_cyc[0], 12);
    checkOutput("sw_latency_wait2", f_cyc[5] - f_cyc[4], 6);
    checkOutput("lw_latency_wait2", f_cyc[6] - f_cyc[5], 7);
    checkOutput("dmem_access_count", d_n, 4);
    checkOutput("sw_r3_we", d_we[0], 1);
    checkOutput("sw_r3_addr", d_addr[0], 4);
    checkOutput("sw_r3_wdata", d_wdata[0], 2);
    checkOutput("lw_r5_we", d_we[1], 0);
    checkOutput("lw_r5_addr", d_addr[1], 4);
    checkOutput("sw_r5_wdata", d_wdata[2], 2);
    checkOutput("sw_r4_addr", d_addr[3], 12);
    checkOutput("sw_r4_wdata", d_wdata[3], 1);
    checkOutput("t2_pc_halt", pc, 8);
    checkOutput("t2_illegal", illegal, 0);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
    end
    checkOutput("halt_no_more_fetch", req_cycles, 0);
    checkOutput("halt_pc_frozen", pc, 8);

    holdReset();
    imem[0] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    applyStimulus(0, 0, 0);
    waitFetches(4, 200);
    checkOutput("beq_self_addr1", f_addr[1], 0);
    checkOutput("beq_self_addr3", f_addr[3], 0);
    checkOutput("beq_latency", f_cyc[2] - f_cyc[1], 3);

    holdReset();
    imem[0]   = enc_i(6'h04, 5'd0, 5'd0, 16'd254);
    imem[255] = enc_i(6'h04, 5'd0, 5'd0, 16'd0);
    applyStimulus(0, 0, 0);
    waitFetches(4, 200);
    checkOutput("branch_to_255", f_addr[1], 255);
    checkOutput("branch_wrap_to_0", f_addr[2], 0);
    checkOutput("branch_to_255_again", f_addr[3], 255);

    holdReset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    imem[1] = enc_r(5'd0, 5'd0, 5'd6, 6'h20);
    imem[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd5);
    imem[3] = enc_i(6'h08, 5'd0, 5'd7, 16'd9);
    imem[4] = enc_i(6'h2B, 5'd0, 5'd6, 16'd16);
    imem[5] = enc_i(6'h2B, 5'd0, 5'd9, 16'd17);
    imem[6] = enc_i(6'h2B, 5'd0, 5'd7, 16'd18);
    applyStimulus(0, 1, 1);
    runUntilHalt(500);
    checkOutput("r0_stays_zero", d_wdata[0], 0);
    checkOutput("r9_reads_zero", d_wdata[1], 0);
    checkOutput("r7_store_addr", d_addr[2], 18);
    checkOutput("r7_store_data", d_wdata[2], 9);
    checkOutput("t5_pc_halt", pc, 7);

    holdReset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd12);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd10);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h22);
    imem[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h24);
    imem[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h25);
    imem[5] = enc_r(5'd1, 5'd2, 5'd2, 6'h2A);
    imem[6] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
    imem[7] = enc_i(6'h2B, 5'd0, 5'd4, 16'd1);
    imem[8] = enc_i(6'h2B, 5'd0, 5'd5, 16'd2);
    imem[9] = enc_i(6'h2B, 5'd0, 5'd2, 16'd3);
    applyStimulus(1, 0, 0);
    runUntilHalt(500);
    checkOutput("sub_result", d_wdata[0], 2);
    checkOutput("and_result", d_wdata[1], 8);
    checkOutput("or_result", d_wdata[2], 14);
    checkOutput("slt_false_result", d_wdata[3], 0);

    holdReset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(6'h05, 5'd1, 5'd0, 16'd2);
    applyStimulus(0, 0, 0);
    runUntilHalt(500);
`ifdef MULTICYCLE_CPU_BNE_EN
    checkOutput("bne_taken_pc", pc, 4);
    checkOutput("bne_illegal", illegal, 0);
`else
    checkOutput("op05_pc", pc, 1);
    checkOutput("op05_illegal", illegal, 1);
`endif

    holdReset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_r(5'd1, 5'd1, 5'd2, 6'h21);
    applyStimulus(0, 0, 0);
    runUntilHalt(500);
    checkOutput("bad_funct_pc", pc, 1);
    checkOutput("bad_funct_illegal", illegal, 1);

    holdReset();
    imem[0] = enc_i(6'h10, 5'd0, 5'd0, 16'd0);
    applyStimulus(0, 0, 0);
    runUntilHalt(500);
    checkOutput("bad_op_pc", pc, 0);
    checkOutput("bad_op_illegal", illegal, 1);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
